regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Writer side of the regfile write port (`rd_addr`/`rd_data`/`write_en`, gated by `stall_i`).
- Collects completed results from the two superscalar execution lanes and buffers them in program order in a small FIFO.
- Drains one result per cycle into the single regfile write port.
- Provides youngest-pending-write forwarding for the two regfile read addresses, so decode never sees stale operands.

Parameters:
- XLEN, 32, data width (matches `XLEN` in constants.vh)
- REG_ADDR_WIDTH, 5, register address width
- DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall_i  in  1  pipeline stall; freezes draining (same net fed to regfile)
- l0_valid  in  1  lane 0 (older) result valid
- l0_addr  in  REG_ADDR_WIDTH  lane 0 destination register
- l0_data  in  XLEN  lane 0 result
- l0_ready  out  1  lane 0 accepted this edge if valid
- l1_valid  in  1  lane 1 (younger) result valid
- l1_addr  in  REG_ADDR_WIDTH  lane 1 destination register
- l1_data  in  XLEN  lane 1 result
- l1_ready  out  1  lane 1 accepted this edge if valid
- rd_addr  out  REG_ADDR_WIDTH  regfile write address (registered)
- rd_data  out  XLEN  regfile write data (registered)
- write_en  out  1  regfile write enable (registered)
- r1_addr  in  REG_ADDR_WIDTH  read address 1 (shared with regfile)
- r2_addr  in  REG_ADDR_WIDTH  read address 2
- r1_fwd_valid  out  1  pending write to r1_addr exists
- r1_fwd_data  out  XLEN  youngest pending data for r1_addr
- r2_fwd_valid  out  1  as r1, for r2_addr
- r2_fwd_data  out  XLEN  as r1, for r2_addr

Behaviour:
- Reset: rst high asynchronously clears the FIFO pointers and count. It also forces write_en=0, rd_addr=0 and rd_data=0, and sets both ready outputs to 0. Anything pending mid-operation is discarded; there is no partial drain.
- Free space: free = DEPTH - count, computed from the registered count only. A same-edge pop is not credited, so there is no combinational path from stall_i to ready.
- Ready outputs: l0_ready = (free >= 1); l1_ready = (free >= 2).
  - With free==1 only lane 0 can be accepted, which preserves program order.
  - If lane 1 is valid alone with free==1, it waits.
- Handshake: a transfer happens on a rising edge when valid && ready. Senders hold addr/data stable until ready.
- Enqueue order per edge: lane 0 first, then lane 1. When both are accepted they occupy consecutive entries.
- Writes to x0: addr==0 is accepted (ready is honoured) but not enqueued, and does not consume space.
- Drain: on each edge with stall_i==0:
  - FIFO non-empty: pop the head into rd_addr/rd_data and set write_en=1.
  - FIFO empty: write_en=0.
- Stall: with stall_i==1 the output register holds its value and write_en is unchanged. The regfile ignores the held write because it sees the same stall. Enqueue continues during stall.
- Latency: a result accepted at edge N appears on the write port after edge N+1 (minimum, with the FIFO empty and no stall). The regfile commits it at edge N+2.
- Simultaneous push and pop on one edge: allowed. count_next = count + pushes - pop. Pointers wrap modulo DEPTH.
- Forwarding (combinational) for rX_addr != 0:
  - Search the FIFO entries youngest to oldest, then the output register (when write_en=1).
  - The first match gives fwd_valid=1 and fwd_data from that match.
  - No match, or rX_addr==0, gives fwd_valid=0 and fwd_data=0.

Decomposition:
- Shared package `wb_pkg`: typedef `wb_entry_t` {addr, data}.
- XLEN and REG_ADDR_WIDTH continue to come from constants.vh.
- One sub-module `wb_fifo`:
  - dual-push / single-pop circular buffer;
  - exposes count, all entries and a valid mask for the forward search.
- Arbitration, output register and forwarding stay in the top level.

Test Plan:
- Single write: reset, then l0 (addr 10, data 256) valid for one edge. Expect write_en=1, rd_addr=10, rd_data=256 for exactly one cycle after the second edge; r1_addr=10 gives fwd_valid=1, fwd_data=256 until commit.
- Dual write, same register: l0 (13, 128) and l1 (13, 64) on one edge. Expect two consecutive write cycles, 128 then 64. While 64 is pending, r1_addr=13 forwards 64 (youngest wins).
- Full with stall: stall_i=1, push two pairs (1,11)/(2,22) and (3,33)/(4,44). Expect count=4 and both ready outputs 0. Release stall: four back-to-back writes 1, 2, 3, 4 in order, then write_en=0.
- Partial space: fill to 3 entries under stall, then present both lanes valid. Expect l0_ready=1 and l1_ready=0; lane 1 is accepted only after a drain frees 2 entries.
- x0 drop: l0 (0, 0xDEAD) and l1 (5, 55). Both are accepted, only the addr-5 write appears, and r1_addr=0 gives fwd_valid=0.
- Reset mid-operation: with 3 entries pending, pulse rst asynchronously between edges. Expect immediately write_en=0, rd_addr=0, rd_data=0 and ready=0; after release, no stale writes and ready=1.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the regfile write-back path: widths and the buffered result entry.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package wb_pkg;

    // Widths mirror XLEN / REG_ADDR_WIDTH from constants.vh.
    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [XLEN-1:0]           data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Lane result handshakes, regfile write port and operand-forwarding bus.
// Latency: n/a (wiring only).
// Backpressure: lanes hold addr/data while valid && !ready.
interface regfile_wb_arbiter_if;
    import wb_pkg::*;

    logic                      l0_valid;
    logic [REG_ADDR_WIDTH-1:0] l0_addr;
    logic [XLEN-1:0]           l0_data;
    logic                      l0_ready;

    logic                      l1_valid;
    logic [REG_ADDR_WIDTH-1:0] l1_addr;
    logic [XLEN-1:0]           l1_data;
    logic                      l1_ready;

    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [XLEN-1:0]           rd_data;
    logic                      write_en;

    logic [REG_ADDR_WIDTH-1:0] r1_addr;
    logic [REG_ADDR_WIDTH-1:0] r2_addr;
    logic                      r1_fwd_valid;
    logic [XLEN-1:0]           r1_fwd_data;
    logic                      r2_fwd_valid;
    logic [XLEN-1:0]           r2_fwd_data;

    // Arbiter side.
    modport slave (
        input  l0_valid, l0_addr, l0_data,
        output l0_ready,
        input  l1_valid, l1_addr, l1_data,
        output l1_ready,
        output rd_addr, rd_data, write_en,
        input  r1_addr, r2_addr,
        output r1_fwd_valid, r1_fwd_data, r2_fwd_valid, r2_fwd_data
    );

    // Execution lanes / decode side.
    modport master (
        output l0_valid, l0_addr, l0_data,
        input  l0_ready,
        output l1_valid, l1_addr, l1_data,
        input  l1_ready,
        input  rd_addr, rd_data, write_en,
        output r1_addr, r2_addr,
        input  r1_fwd_valid, r1_fwd_data, r2_fwd_valid, r2_fwd_data
    );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// Dual-push / single-pop circular buffer of write-back entries, exposed oldest-first.
// Latency: push visible at outputs after one edge; pop removes head on the edge.
// Backpressure: none internally; caller must never push beyond free space.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push0,
    input  wb_entry_t              push0_dat,
    input  logic                   push1,
    input  wb_entry_t              push1_dat,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output wb_entry_t              entries [DEPTH],
    output logic [DEPTH-1:0]       vld
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         mem_q   [DEPTH];
    wb_entry_t         mem_d   [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic [PW-1:0]     slot;

    // Next state: lane 0 lands first, lane 1 in the following slot; pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        slot     = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push0) begin
            mem_d[slot] = push0_dat;
            slot        = slot + PW'(1);
        end
        if (push1) begin
            mem_d[slot] = push1_dat;
            slot        = slot + PW'(1);
        end
        wr_ptr_d = slot;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push0) + CW'(push1) - CW'(pop);
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Present entries in age order (index 0 = head) with a validity mask for the forward search.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = mem_q[rd_ptr_q + PW'(i)];
            vld[i]     = (CW'(i) < count_q);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Buffers two-lane results in program order, drains one per cycle to the regfile, forwards pending data.
// Latency: result accepted at edge N drives the write port after edge N+1 (empty FIFO, no stall).
// Backpressure: l0_ready needs 1 free entry, l1_ready needs 2, from registered count only.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]   count;
    logic [CW-1:0]   free;
    wb_entry_t       entries [DEPTH];
    logic [DEPTH-1:0] vld;

    logic            l0_ready;
    logic            l1_ready;
    logic            push0;
    logic            push1;
    logic            pop;
    wb_entry_t       push0_dat;
    wb_entry_t       push1_dat;

    wb_entry_t       wr_q, wr_d;
    logic            we_q, we_d;

    logic            r1_vld, r2_vld;
    logic [XLEN-1:0] r1_dat, r2_dat;

    // Space check ignores a same-edge pop so stall_i never reaches the ready outputs.
    always_comb begin
        free      = CW'(DEPTH) - count;
        l0_ready  = !rst && (free >= CW'(1));
        l1_ready  = !rst && (free >= CW'(2));
        push0     = bus.l0_valid && l0_ready && (bus.l0_addr != '0);
        push1     = bus.l1_valid && l1_ready && (bus.l1_addr != '0);
        push0_dat = '{addr: bus.l0_addr, data: bus.l0_data};
        push1_dat = '{addr: bus.l1_addr, data: bus.l1_data};
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push0     (push0),
        .push0_dat (push0_dat),
        .push1     (push1),
        .push1_dat (push1_dat),
        .pop       (pop),
        .count     (count),
        .entries   (entries),
        .vld       (vld)
    );

    // Drain the head into the write port unless stalled; a stall freezes the whole output register.
    always_comb begin
        wr_d = wr_q;
        we_d = we_q;
        pop  = 1'b0;
        if (!stall_i) begin
            if (count != '0) begin
                pop  = 1'b1;
                wr_d = entries[0];
                we_d = 1'b1;
            end else begin
                we_d = 1'b0;
            end
        end
    end

    // Regfile write-port register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            we_q <= 1'b0;
        end else begin
            wr_q <= wr_d;
            we_q <= we_d;
        end
    end

    // Forward search: output register first, then FIFO oldest to youngest so the youngest match wins.
    always_comb begin
        r1_vld = 1'b0;
        r1_dat = '0;
        r2_vld = 1'b0;
        r2_dat = '0;
        if (bus.r1_addr != '0) begin
            if (we_q && (wr_q.addr == bus.r1_addr)) begin
                r1_vld = 1'b1;
                r1_dat = wr_q.data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[i] && (entries[i].addr == bus.r1_addr)) begin
                    r1_vld = 1'b1;
                    r1_dat = entries[i].data;
                end
            end
        end
        if (bus.r2_addr != '0) begin
            if (we_q && (wr_q.addr == bus.r2_addr)) begin
                r2_vld = 1'b1;
                r2_dat = wr_q.data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (vld[i] && (entries[i].addr == bus.r2_addr)) begin
                    r2_vld = 1'b1;
                    r2_dat = entries[i].data;
                end
            end
        end
    end

    assign bus.l0_ready     = l0_ready;
    assign bus.l1_ready     = l1_ready;
    assign bus.rd_addr      = wr_q.addr;
    assign bus.rd_data      = wr_q.data;
    assign bus.write_en     = we_q;
    assign bus.r1_fwd_valid = r1_vld;
    assign bus.r1_fwd_data  = r1_dat;
    assign bus.r2_fwd_valid = r2_vld;
    assign bus.r2_fwd_data  = r2_dat;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: ordering, stall, partial space, x0 drop, async reset.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: stimulus honours ready before dropping valid.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall_i = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .stall_i (stall_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".we"}, 32'(bus.write_en), 32'(we));
        if (we) begin
            chk({tag, ".addr"}, 32'(bus.rd_addr), 32'(a));
            chk({tag, ".data"}, bus.rd_data, d);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, ".l0_ready"}, 32'(bus.l0_ready), 32'(r0));
        chk({tag, ".l1_ready"}, 32'(bus.l1_ready), 32'(r1));
    endtask

    task automatic chk_f1(input string tag, input logic v, input logic [31:0] d);
        chk({tag, ".r1_fwd_valid"}, 32'(bus.r1_fwd_valid), 32'(v));
        chk({tag, ".r1_fwd_data"}, bus.r1_fwd_data, d);
    endtask

    task automatic chk_f2(input string tag, input logic v, input logic [31:0] d);
        chk({tag, ".r2_fwd_valid"}, 32'(bus.r2_fwd_valid), 32'(v));
        chk({tag, ".r2_fwd_data"}, bus.r2_fwd_data, d);
    endtask

    task automatic lanes(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        bus.l0_valid = v0; bus.l0_addr = a0; bus.l0_data = d0;
        bus.l1_valid = v1; bus.l1_addr = a1; bus.l1_data = d1;
    endtask

    initial begin
        lanes(0, 0, 0, 0, 0, 0);
        bus.r1_addr = '0;
        bus.r2_addr = '0;

        // Reset state
        #2;
        chk_wr("rst", 0, 0, 0);
        chk("rst.rd_addr", 32'(bus.rd_addr), 32'd0);
        chk("rst.rd_data", bus.rd_data, 32'd0);
        chk_rdy("rst", 0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_rdy("post_rst", 1, 1);
        chk_wr("post_rst", 0, 0, 0);

        // Single write
        lanes(1, 5'd10, 32'd256, 0, 0, 0);
        bus.r1_addr = 5'd10;
        tick();
        chk_wr("single.e1", 0, 0, 0);
        chk_f1("single.e1", 1, 32'd256);
        lanes(0, 0, 0, 0, 0, 0);
        tick();
        chk_wr("single.e2", 1, 5'd10, 32'd256);
        chk_f1("single.e2", 1, 32'd256);
        tick();
        chk_wr("single.e3", 0, 0, 0);
        chk_f1("single.e3", 0, 32'd0);

        // Dual write, same register: youngest wins forwarding
        lanes(1, 5'd13, 32'd128, 1, 5'd13, 32'd64);
        bus.r1_addr = 5'd13;
        tick();
        chk_wr("dual.e1", 0, 0, 0);
        chk_f1("dual.e1", 1, 32'd64);
        lanes(0, 0, 0, 0, 0, 0);
        tick();
        chk_wr("dual.e2", 1, 5'd13, 32'd128);
        chk_f1("dual.e2", 1, 32'd64);
        tick();
        chk_wr("dual.e3", 1, 5'd13, 32'd64);
        chk_f1("dual.e3", 1, 32'd64);
        tick();
        chk_wr("dual.e4", 0, 0, 0);

        // Full under stall, then ordered drain
        stall_i = 1'b1;
        lanes(1, 5'd1, 32'd11, 1, 5'd2, 32'd22);
        tick();
        chk_rdy("full.p1", 1, 1);
        lanes(1, 5'd3, 32'd33, 1, 5'd4, 32'd44);
        tick();
        lanes(0, 0, 0, 0, 0, 0);
        chk_rdy("full.p2", 0, 0);
        chk_wr("full.p2", 0, 0, 0);
        bus.r2_addr = 5'd3;
        #1;
        chk_f2("full.p2", 1, 32'd33);
        tick();
        chk_rdy("full.hold", 0, 0);
        chk_wr("full.hold", 0, 0, 0);
        stall_i = 1'b0;
        tick();
        chk_wr("full.d1", 1, 5'd1, 32'd11);
        tick();
        chk_wr("full.d2", 1, 5'd2, 32'd22);
        tick();
        chk_wr("full.d3", 1, 5'd3, 32'd33);
        tick();
        chk_wr("full.d4", 1, 5'd4, 32'd44);
        tick();
        chk_wr("full.d5", 0, 0, 0);
        chk_rdy("full.d5", 1, 1);

        // Partial space: lane 1 waits for two free entries
        stall_i = 1'b1;
        lanes(1, 5'd6, 32'd66, 1, 5'd7, 32'd77);
        tick();
        lanes(1, 5'd8, 32'd88, 0, 0, 0);
        tick();
        lanes(1, 5'd9, 32'd99, 1, 5'd10, 32'd100);
        #1;
        chk_rdy("part.cnt3", 1, 0);
        tick();
        bus.l0_valid = 1'b0;
        chk_rdy("part.cnt4", 0, 0);
        stall_i = 1'b0;
        tick();
        chk_wr("part.d1", 1, 5'd6, 32'd66);
        chk_rdy("part.d1", 1, 0);
        tick();
        chk_wr("part.d2", 1, 5'd7, 32'd77);
        chk_rdy("part.d2", 1, 1);
        tick();
        bus.l1_valid = 1'b0;
        chk_wr("part.d3", 1, 5'd8, 32'd88);
        tick();
        chk_wr("part.d4", 1, 5'd9, 32'd99);
        tick();
        chk_wr("part.d5", 1, 5'd10, 32'd100);
        tick();
        chk_wr("part.d6", 0, 0, 0);

        // x0 drop
        lanes(1, 5'd0, 32'hDEAD, 1, 5'd5, 32'd55);
        bus.r1_addr = 5'd0;
        bus.r2_addr = 5'd5;
        #1;
        chk_rdy("x0.pre", 1, 1);
        tick();
        lanes(0, 0, 0, 0, 0, 0);
        chk_f1("x0.e1", 0, 32'd0);
        chk_f2("x0.e1", 1, 32'd55);
        tick();
        chk_wr("x0.e2", 1, 5'd5, 32'd55);
        chk_f1("x0.e2", 0, 32'd0);
        tick();
        chk_wr("x0.e3", 0, 0, 0);

        // Asynchronous reset mid-operation
        stall_i = 1'b1;
        lanes(1, 5'd11, 32'd111, 1, 5'd12, 32'd122);
        tick();
        lanes(1, 5'd13, 32'd133, 0, 0, 0);
        tick();
        lanes(0, 0, 0, 0, 0, 0);
        stall_i = 1'b0;
        bus.r1_addr = 5'd12;
        tick();
        chk_wr("arst.pre", 1, 5'd11, 32'd111);
        chk_f1("arst.pre", 1, 32'd122);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.we", 32'(bus.write_en), 32'd0);
        chk("arst.rd_addr", 32'(bus.rd_addr), 32'd0);
        chk("arst.rd_data", bus.rd_data, 32'd0);
        chk_rdy("arst", 0, 0);
        chk_f1("arst", 0, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk_rdy("arst.rel", 1, 1);
        tick();
        chk_wr("arst.e1", 0, 0, 0);
        tick();
        chk_wr("arst.e2", 0, 0, 0);
        chk_f1("arst.e2", 0, 32'd0);
        chk_rdy("arst.e2", 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
